// File: rtl/matrix_vertex_apply_if.sv
// Handshake bundle for matrix_vertex_apply.
// It carries the matrix load, the vertex input and the transformed vertex output.
interface matrix_vertex_apply_if #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned IN_BITS   = 8,
    parameter int unsigned NUM_VERTS = 8
);
    logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] mat_in;
    logic                                   mat_valid;
    logic                                   mat_ready;
    logic [SIZE-1:0][IN_BITS-1:0]           vin;
    logic                                   vin_valid;
    logic                                   vin_ready;
    logic [SIZE-1:0][IN_BITS-1:0]           vout;
    logic [$clog2(NUM_VERTS+1)-1:0]         vout_idx;
    logic                                   vout_valid;
    logic                                   vout_ready;
    logic                                   done;

    modport slave (
        input  mat_in, mat_valid, vin, vin_valid, vout_ready,
        output mat_ready, vin_ready, vout, vout_idx, vout_valid, done
    );

    modport master (
        output mat_in, mat_valid, vin, vin_valid, vout_ready,
        input  mat_ready, vin_ready, vout, vout_idx, vout_valid, done
    );
endinterface

// File: rtl/matrix_vertex_apply.sv
// Latches a SIZE x SIZE fixed-point matrix and streams NUM_VERTS vertices through it.
// Each vertex is computed one output row per cycle. Define MATVEC_ROUND_EN for round-half-up.
module matrix_vertex_apply #(
    parameter int unsigned SIZE         = 3,
    parameter int unsigned IN_BITS      = 8,
    parameter int unsigned IN_FRAC_BITS = 2,
    parameter int unsigned NUM_VERTS    = 8
) (
    input logic                  clk,
    input logic                  rst,
    matrix_vertex_apply_if.slave bus
);
    localparam int unsigned AccW = 2 * IN_BITS + $clog2(SIZE);
    localparam int unsigned RowW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned IdxW = $clog2(NUM_VERTS + 1);
    localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (IN_BITS - 1)) - 1);
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;
`ifdef MATVEC_ROUND_EN
    localparam logic signed [AccW-1:0] RoundAdd =
        (IN_FRAC_BITS > 0) ? AccW'(1 << (IN_FRAC_BITS - 1)) : '0;
`endif

    typedef enum logic [1:0] {StIdle, StWaitV, StCalc, StOut} stateE;

    stateE stateQ, stateD;

    logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] matQ;
    logic [SIZE-1:0][IN_BITS-1:0]           vertQ;
    logic [SIZE-1:0][IN_BITS-1:0]           voutQ;
    logic [RowW-1:0]                        rowQ;
    logic [IdxW-1:0]                        idxQ;
    logic                                   doneQ;

    logic matFire, vinFire, voutFire, lastRow, lastVert;
    logic signed [2*IN_BITS-1:0] prod;
    logic signed [AccW-1:0]      acc, accR, shifted;
    logic [IN_BITS-1:0]          rowResult;

    assign bus.mat_ready  = (stateQ == StIdle);
    assign bus.vin_ready  = (stateQ == StWaitV);
    assign bus.vout_valid = (stateQ == StOut);
    assign bus.vout       = voutQ;
    assign bus.vout_idx   = idxQ;
    assign bus.done       = doneQ;

    assign matFire  = bus.mat_valid && bus.mat_ready;
    assign vinFire  = bus.vin_valid && bus.vin_ready;
    assign voutFire = bus.vout_ready && bus.vout_valid;
    assign lastRow  = (rowQ == RowW'(SIZE - 1));
    assign lastVert = (idxQ == IdxW'(NUM_VERTS - 1));

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (matFire) stateD = StWaitV;
            StWaitV: if (vinFire) stateD = StCalc;
            StCalc:  if (lastRow) stateD = StOut;
            StOut:   if (voutFire) stateD = lastVert ? StIdle : StWaitV;
            default: stateD = StIdle;
        endcase
    end

    // Dot product of the current matrix row with the latched vertex.
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int r = 0; r < SIZE; r++) begin
            prod = $signed(matQ[rowQ][r]) * $signed(vertQ[r]);
            acc  = acc + AccW'(prod);
        end
`ifdef MATVEC_ROUND_EN
        accR = acc + RoundAdd;
`else
        accR = acc;
`endif
        shifted = accR >>> IN_FRAC_BITS;
        if (shifted > SatMax) begin
            rowResult = SatMax[IN_BITS-1:0];
        end else if (shifted < SatMin) begin
            rowResult = SatMin[IN_BITS-1:0];
        end else begin
            rowResult = shifted[IN_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matQ  <= '0;
            vertQ <= '0;
            voutQ <= '0;
            rowQ  <= '0;
            idxQ  <= '0;
            doneQ <= 1'b0;
        end else begin
            doneQ <= voutFire && lastVert;
            if (matFire) begin
                matQ <= bus.mat_in;
                idxQ <= '0;
            end
            if (vinFire) begin
                vertQ <= bus.vin;
                rowQ  <= '0;
            end
            if (stateQ == StCalc) begin
                voutQ[rowQ] <= rowResult;
                rowQ        <= rowQ + RowW'(1);
            end
            if (voutFire) begin
                idxQ <= idxQ + IdxW'(1);
            end
        end
    end
endmodule
